// File: rtl/motor_cmd_timebase_pkg.sv
// -----------------------------------------------------------------------------
// motor_pkg
// Shared types and constants for the motor command timebase and the
// downstream motorcontrol block.
//   ctl_state_t    : control state of the timebase (IDLE, RUN, REV_BRAKE)
//   PERIOD_DEFAULT : clock cycles per PWM period (20 ms at 100 MHz)
//   PW_FWD/PW_REV/PW_BRAKE : pulse-width thresholds used by motorcontrol
//   is_reversal()  : true when applying a command would flip a running motor
// -----------------------------------------------------------------------------
package motor_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    REV_BRAKE = 2'd2
  } ctl_state_t;

  localparam int PERIOD_DEFAULT = 2000000;
  localparam int PW_FWD         = 200000;
  localparam int PW_REV         = 100000;
  localparam int PW_BRAKE       = 149200;

  // A reversal is a running (unbraked) motor being asked to drive the other
  // way without braking first.
  function automatic logic is_reversal(input logic cur_dir,
                                       input logic cur_brake,
                                       input logic new_dir,
                                       input logic new_brake);
    return !cur_brake && !new_brake && (new_dir != cur_dir);
  endfunction

endpackage

// File: rtl/motor_cmd_timebase_if.sv
// -----------------------------------------------------------------------------
// motor_cmd_timebase_if
// Valid/ready command channel into the motor command timebase.
//   cmd_valid : a command is offered (master -> slave)
//   cmd_ready : the timebase can accept a command (slave -> master)
//   cmd_dir   : requested direction, 1 = S1 / 2 ms, 0 = S2 / 1 ms
//   cmd_brake : requested brake (neutral pulse)
// -----------------------------------------------------------------------------
interface motor_cmd_timebase_if;

  logic cmd_valid;
  logic cmd_ready;
  logic cmd_dir;
  logic cmd_brake;

  modport master (
    output cmd_valid,
    output cmd_dir,
    output cmd_brake,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_dir,
    input  cmd_brake,
    output cmd_ready
  );

endinterface

// File: rtl/motor_cmd_timebase_period_counter.sv
// -----------------------------------------------------------------------------
// period_counter
// Free-running PWM period counter, 0 .. PERIOD-1, wrapping to 0.
//   clk    : system clock
//   reset  : synchronous, active-high reset
//   enable : count when high; the counter clears whenever it is low
//   count  : registered counter value
//   last   : registered, high exactly while count == PERIOD-1
// -----------------------------------------------------------------------------
module period_counter #(
  parameter int PERIOD = 2000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [29:0] count,
  output logic        last
);

  localparam logic [29:0] LAST = 30'(PERIOD - 1);

  logic [29:0] count_nxt;

  always_comb begin
    count_nxt = 30'd0;
    if (enable && (count != LAST)) begin
      count_nxt = count + 30'd1;
    end
  end

  // last is derived from the next count so it lines up with count itself
  // while both remain registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 30'd0;
      last  <= 1'b0;
    end else begin
      count <= count_nxt;
      last  <= (count_nxt == LAST);
    end
  end

endmodule

// File: rtl/motor_cmd_timebase.sv
// -----------------------------------------------------------------------------
// motor_cmd_timebase
// Timebase and command sequencer feeding motorcontrol. Produces the period
// counter and motorcontrol's reset, and applies direction/brake commands only
// at period boundaries so every PWM period is glitch-free. A running motor
// commanded to reverse is first held in brake for REV_BRAKE_PERIODS periods.
//   clk         : system clock
//   reset       : synchronous, active-high reset
//   cmd         : command channel (valid/ready, dir, brake), slave side
//   count_out   : 30-bit period counter, drives motorcontrol count_in
//   motor_reset : drives motorcontrol reset (high while idle)
//   direction   : applied direction
//   motor_brake : applied brake
//   period_tick : one-cycle pulse on the last cycle of each period
//   reversing   : high while a forced reversal brake is in progress
// -----------------------------------------------------------------------------
module motor_cmd_timebase
  import motor_pkg::*;
#(
  parameter int PERIOD            = PERIOD_DEFAULT,
  parameter int REV_BRAKE_PERIODS = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  motor_cmd_timebase_if.slave  cmd,
  output logic [29:0]          count_out,
  output logic                 motor_reset,
  output logic                 direction,
  output logic                 motor_brake,
  output logic                 period_tick,
  output logic                 reversing
);

  localparam logic [7:0] REV_CNT_INIT = 8'(REV_BRAKE_PERIODS);

  ctl_state_t  state;
  logic        cmd_ready_r;
  logic        accept;
  logic        pend_valid;
  logic        pend_dir;
  logic        pend_brake;
  logic        target_dir;
  logic [7:0]  rev_cnt;

  assign cmd.cmd_ready = cmd_ready_r;
  assign accept        = cmd.cmd_valid && cmd_ready_r;

  // The counter only runs once a first command has left IDLE.
  period_counter #(
    .PERIOD (PERIOD)
  ) u_period_counter (
    .clk    (clk),
    .reset  (reset),
    .enable (state != IDLE),
    .count  (count_out),
    .last   (period_tick)
  );

  // period_tick marks the PERIOD-1 cycle, so acting on it updates outputs on
  // the wrap edge. pend_valid is sampled in that same cycle, which makes a
  // command accepted during PERIOD-1 wait for the following boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      motor_reset <= 1'b1;
      direction   <= 1'b0;
      motor_brake <= 1'b0;
      reversing   <= 1'b0;
      cmd_ready_r <= 1'b1;
      pend_valid  <= 1'b0;
      pend_dir    <= 1'b0;
      pend_brake  <= 1'b0;
      target_dir  <= 1'b0;
      rev_cnt     <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          // First command starts the motor directly, no reversal check.
          if (accept) begin
            state       <= RUN;
            motor_reset <= 1'b0;
            direction   <= cmd.cmd_dir;
            motor_brake <= cmd.cmd_brake;
          end
        end

        RUN: begin
          if (period_tick && pend_valid) begin
            pend_valid <= 1'b0;
            if (is_reversal(direction, motor_brake, pend_dir, pend_brake)) begin
              // Brake first; direction flips only after the brake interval.
              motor_brake <= 1'b1;
              target_dir  <= pend_dir;
              rev_cnt     <= REV_CNT_INIT;
              reversing   <= 1'b1;
              state       <= REV_BRAKE;
            end else begin
              direction   <= pend_dir;
              motor_brake <= pend_brake;
              cmd_ready_r <= 1'b1;
            end
          end else if (accept) begin
            pend_valid  <= 1'b1;
            pend_dir    <= cmd.cmd_dir;
            pend_brake  <= cmd.cmd_brake;
            cmd_ready_r <= 1'b0;
          end
        end

        REV_BRAKE: begin
          if (period_tick) begin
            rev_cnt <= rev_cnt - 8'd1;
            if (rev_cnt == 8'd1) begin
              direction   <= target_dir;
              motor_brake <= 1'b0;
              reversing   <= 1'b0;
              cmd_ready_r <= 1'b1;
              state       <= RUN;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_motor_cmd_timebase.sv
// -----------------------------------------------------------------------------
// tb_motor_cmd_timebase
// Directed bench for motor_cmd_timebase with PERIOD=10, REV_BRAKE_PERIODS=2.
// A timeline model (absolute cycle numbers, a pending queue and a reversal
// end time) predicts every output; a negedge process compares each cycle,
// and the stimulus adds literal expectations at key points.
// -----------------------------------------------------------------------------
module tb_motor_cmd_timebase;
  import motor_pkg::*;

  localparam int P   = 10;
  localparam int REV = 2;

  logic        clk;
  logic        reset;
  logic [29:0] count_out;
  logic        motor_reset;
  logic        direction;
  logic        motor_brake;
  logic        period_tick;
  logic        reversing;

  motor_cmd_timebase_if cif ();

  motor_cmd_timebase #(
    .PERIOD            (P),
    .REV_BRAKE_PERIODS (REV)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd         (cif),
    .count_out   (count_out),
    .motor_reset (motor_reset),
    .direction   (direction),
    .motor_brake (motor_brake),
    .period_tick (period_tick),
    .reversing   (reversing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // ---------------- timeline model ----------------
  typedef struct {
    bit d;
    bit b;
    int acc;
  } cmd_t;

  cmd_t pend[$];
  cmd_t head;
  int   cyc       = 0;
  int   start     = 0;
  int   rev_until = 0;
  bit   running   = 0;
  bit   m_dir     = 0;
  bit   m_brake   = 0;
  bit   rev_dir   = 0;
  bit   started   = 0;
  bit   acc       = 0;
  bit   at_last   = 0;
  int   e_count   = 0;
  bit   e_tick    = 0;
  bit   e_mreset  = 1;
  bit   e_rev     = 0;
  bit   e_ready   = 1;

  // Each posedge ends cycle 'cyc' (inputs of that cycle) and the expected
  // outputs for cycle cyc+1 are derived from the timeline.
  always @(posedge clk) begin
    if (reset) begin
      started   = 1;
      running   = 0;
      m_dir     = 0;
      m_brake   = 0;
      rev_until = 0;
      pend.delete();
    end else if (started) begin
      acc = cif.cmd_valid && e_ready;
      if (!running) begin
        if (acc) begin
          running = 1;
          start   = cyc + 1;
          m_dir   = cif.cmd_dir;
          m_brake = cif.cmd_brake;
        end
      end else begin
        at_last = ((cyc - start) % P) == P - 1;
        if (at_last) begin
          if (cyc + 1 == rev_until) begin
            m_dir   = rev_dir;
            m_brake = 0;
          end else if (cyc + 1 > rev_until && pend.size() > 0 && pend[0].acc < cyc) begin
            head = pend.pop_front();
            if (!m_brake && !head.b && head.d != m_dir) begin
              m_brake   = 1;
              rev_dir   = head.d;
              rev_until = cyc + 1 + REV * P;
            end else begin
              m_dir   = head.d;
              m_brake = head.b;
            end
          end
        end
        if (acc) pend.push_back('{d: cif.cmd_dir, b: cif.cmd_brake, acc: cyc});
      end
    end
    cyc      = cyc + 1;
    e_count  = running ? (cyc - start) % P : 0;
    e_tick   = running && (e_count == P - 1);
    e_mreset = !running;
    e_rev    = running && (cyc < rev_until);
    e_ready  = !running || (pend.size() == 0 && !e_rev);
  end

  // Compare every cycle once reset has been seen.
  always @(negedge clk) begin
    if (started) begin
      chk("count_out",   32'(count_out),     32'(e_count));
      chk("motor_reset", 32'(motor_reset),   32'(e_mreset));
      chk("direction",   32'(direction),     32'(m_dir));
      chk("motor_brake", 32'(motor_brake),   32'(m_brake));
      chk("period_tick", 32'(period_tick),   32'(e_tick));
      chk("reversing",   32'(reversing),     32'(e_rev));
      chk("cmd_ready",   32'(cif.cmd_ready), 32'(e_ready));
    end
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic send(input bit d, input bit b);
    cif.cmd_valid = 1'b1;
    cif.cmd_dir   = d;
    cif.cmd_brake = b;
    @(negedge clk);
    cif.cmd_valid = 1'b0;
  endtask

  task automatic wait_count(input int k);
    int n = 0;
    while (e_count != k && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      checks++;
      errors++;
      $display("FAIL wait_count timeout waiting for count %0d", k);
    end
  endtask

  initial begin
    reset         = 1'b1;
    cif.cmd_valid = 1'b0;
    cif.cmd_dir   = 1'b0;
    cif.cmd_brake = 1'b0;

    // 1: reset then idle
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    chk("t1 count_out",   32'(count_out),     32'd0);
    chk("t1 motor_reset", 32'(motor_reset),   32'd1);
    chk("t1 cmd_ready",   32'(cif.cmd_ready), 32'd1);

    // 2: start running dir=1
    send(1'b1, 1'b0);
    chk("t2 motor_reset", 32'(motor_reset),   32'd0);
    chk("t2 direction",   32'(direction),     32'd1);
    chk("t2 count_out",   32'(count_out),     32'd0);
    chk("t2 cmd_ready",   32'(cif.cmd_ready), 32'd1);
    repeat (9) @(negedge clk);
    chk("t2 tick",        32'(period_tick),   32'd1);
    chk("t2 count9",      32'(count_out),     32'd9);

    // 3: reversal request mid-period
    wait_count(4);
    send(1'b0, 1'b0);
    chk("t3 ready after accept", 32'(cif.cmd_ready), 32'd0);
    wait_count(0);
    chk("t3 brake",     32'(motor_brake),   32'd1);
    chk("t3 reversing", 32'(reversing),     32'd1);
    chk("t3 direction", 32'(direction),     32'd1);
    chk("t3 ready",     32'(cif.cmd_ready), 32'd0);
    repeat (20) @(negedge clk);
    chk("t3 end direction", 32'(direction),     32'd0);
    chk("t3 end brake",     32'(motor_brake),   32'd0);
    chk("t3 end reversing", 32'(reversing),     32'd0);
    chk("t3 end ready",     32'(cif.cmd_ready), 32'd1);

    // 4: command accepted on the count==9 cycle waits one extra period
    wait_count(9);
    send(1'b1, 1'b1);
    chk("t4 wrap1 count", 32'(count_out),   32'd0);
    chk("t4 wrap1 dir",   32'(direction),   32'd0);
    chk("t4 wrap1 brake", 32'(motor_brake), 32'd0);
    repeat (10) @(negedge clk);
    chk("t4 wrap2 dir",   32'(direction),   32'd1);
    chk("t4 wrap2 brake", 32'(motor_brake), 32'd1);

    // 5: brake then reverse from brake: no forced interval
    wait_count(3);
    send(1'b1, 1'b0);
    wait_count(0);
    chk("t5 run dir",   32'(direction),   32'd1);
    chk("t5 run brake", 32'(motor_brake), 32'd0);
    wait_count(3);
    send(1'b0, 1'b1);
    wait_count(0);
    chk("t5 brake",     32'(motor_brake), 32'd1);
    chk("t5 brake rev", 32'(reversing),   32'd0);
    wait_count(3);
    send(1'b0, 1'b0);
    wait_count(0);
    chk("t5 dir0",      32'(direction),   32'd0);
    chk("t5 brake0",    32'(motor_brake), 32'd0);
    chk("t5 rev0",      32'(reversing),   32'd0);

    // 6: reset during REV_BRAKE at count 4, command offered during reset
    wait_count(3);
    send(1'b1, 1'b0);
    wait_count(0);
    chk("t6 reversing", 32'(reversing), 32'd1);
    wait_count(4);
    reset         = 1'b1;
    cif.cmd_valid = 1'b1;
    cif.cmd_dir   = 1'b1;
    cif.cmd_brake = 1'b0;
    @(negedge clk);
    chk("t6 motor_reset", 32'(motor_reset),   32'd1);
    chk("t6 count_out",   32'(count_out),     32'd0);
    chk("t6 reversing",   32'(reversing),     32'd0);
    chk("t6 ready",       32'(cif.cmd_ready), 32'd1);
    chk("t6 brake",       32'(motor_brake),   32'd0);
    @(negedge clk);
    reset         = 1'b0;
    cif.cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("t6 still idle",  32'(motor_reset), 32'd1);
    chk("t6 idle count",  32'(count_out),   32'd0);
    chk("t6 idle dir",    32'(direction),   32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/motor_cmd_timebase.md
Name: motor_cmd_timebase

Overview:
- Upstream stage of motorcontrol. Generates the 30-bit period counter that motorcontrol compares against its pulse-width thresholds, plus motorcontrol's reset.
- Accepts direction/brake commands through a valid/ready handshake and applies them only at period boundaries, so each PWM period is glitch-free.
- Inserts a forced brake interval whenever a running motor is commanded to reverse direction.

Parameters:
- PERIOD, 2000000: clock cycles per PWM period (20 ms at 100 MHz); legal range 2..2^30.
- REV_BRAKE_PERIODS, 5: whole periods of forced brake before a direction reversal takes effect; legal range 1..255.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  a command is offered.
- cmd_ready  out  1  the block can accept a command.
- cmd_dir  in  1  requested direction (1 = S1 / 2 ms, 0 = S2 / 1 ms).
- cmd_brake  in  1  requested brake (1.492 ms neutral pulse).
- count_out  out  30  period counter; drives motorcontrol count_in.
- motor_reset  out  1  drives motorcontrol reset.
- direction  out  1  applied direction; drives motorcontrol direction.
- motor_brake  out  1  applied brake; drives motorcontrol motor_brake.
- period_tick  out  1  one-cycle pulse on the last cycle of each period.
- reversing  out  1  high while a forced reversal brake is in progress.

Behaviour:
- All outputs are registered. The clock is named clk; reset is synchronous and active-high.
- Reset values: state IDLE, count_out=0, motor_reset=1, direction=0, motor_brake=0, period_tick=0, reversing=0, cmd_ready=1, pending register empty.
- Handshake:
  - A command is accepted on a cycle where cmd_valid && cmd_ready; it is latched into a one-entry pending register.
  - cmd_ready = !pending_valid && state != REV_BRAKE. It falls in the cycle after acceptance.
- IDLE:
  - count_out is held at 0 and motor_reset=1.
  - When a command is accepted, the next cycle enters RUN with count_out=0, motor_reset=0, and direction/motor_brake loaded directly from the command.
  - No reversal check is made from IDLE; the pending register stays empty.
- Counter (RUN and REV_BRAKE):
  - count_out increments by 1 each cycle and wraps from PERIOD-1 to 0.
  - period_tick=1 exactly on cycles where count_out==PERIOD-1.
- Boundary (the edge on which count_out wraps to 0):
  - The pending command is applied only if pending_valid was already 1 in the PERIOD-1 cycle.
  - A command accepted during the PERIOD-1 cycle itself waits for the following boundary.
- Applying a command in RUN:
  - Reversal case: current motor_brake==0, cmd_brake==0 and cmd_dir!=direction.
    - Set motor_brake=1 and keep direction unchanged.
    - Store the target direction, load rev_cnt=REV_BRAKE_PERIODS, enter REV_BRAKE, set reversing=1.
  - Otherwise: direction and motor_brake take the command values immediately at the boundary.
  - In both cases the pending register is cleared.
- REV_BRAKE:
  - rev_cnt decrements at each boundary.
  - At the boundary where rev_cnt goes 1→0: direction=target, motor_brake=0, reversing=0, state RUN.
  - Total brake time is exactly REV_BRAKE_PERIODS full periods.
  - No command is accepted while in REV_BRAKE.
- Outputs are stable for an entire period: direction and motor_brake change only on the wrap edge, or on the IDLE→RUN edge.
- Reset mid-operation (any state, any count): all state returns to the reset values on the next edge. A pending command is discarded and a reversal is aborted.
- Widths: rev_cnt is 8 bits. The counter comparison is done at 30 bits, with PERIOD-1 computed as a 30-bit constant.

Decomposition:
- Package motor_pkg:
  - Enum CtlState {IDLE, RUN, REV_BRAKE}.
  - Constants PERIOD_DEFAULT=2000000, PW_FWD=200000, PW_REV=100000, PW_BRAKE=149200.
  - motorcontrol also imports these constants.
- Sub-module period_counter (parameter PERIOD):
  - Inputs clk, reset, enable.
  - Outputs count[29:0] and last (count==PERIOD-1).
  - The counter clears whenever enable=0.

Test Plan (PERIOD=10, REV_BRAKE_PERIODS=2):
1. Reset held 3 cycles then released, no command → count_out=0, motor_reset=1, cmd_ready=1 indefinitely, period_tick never asserts.
2. From IDLE, accept {dir=1,brake=0} at cycle t → at t+1: motor_reset=0, direction=1, count_out=0; period_tick at t+10, t+20, …; cmd_ready back to 1 at t+1.
3. Running dir=1, accept {dir=0,brake=0} mid-period → at the next wrap motor_brake=1, reversing=1, direction=1, cmd_ready=0; two wraps later direction=0, motor_brake=0, reversing=0, cmd_ready=1.
4. Accept a command exactly on the count_out==9 cycle → outputs unchanged at that wrap; new values appear at the following wrap (10 cycles later).
5. Running dir=1, accept {dir=0,brake=1}, then {dir=0,brake=0} → the first applies brake at the next wrap with no reversal; the second applies dir=0 at the subsequent wrap with reversing never asserted.
6. Assert reset during REV_BRAKE at count_out=4 → next cycle all reset values (motor_reset=1, count_out=0, reversing=0, cmd_ready=1); a command offered during reset is not accepted.
